mux: RTL and testbench
======================

MUX -- requirements
Module: mux

Interface
REQ-001 Parameter N_IN, default 2: number of 1-bit data inputs; legal range 2..64.
REQ-002 Parameter SEL_W, default 1: select width; SHALL equal ceil(log2(N_IN)); other values are an elaboration error.
REQ-003 Parameter REG_OUT, default 1: 1 = registered output, 0 = purely combinational output.
REQ-004 clk  input  1  sole clock; rising-edge active.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in  input  N_IN  data inputs; bit i is candidate i.
REQ-007 sel  input  SEL_W  index of the data bit routed to out.
REQ-008 out  output  1  selected data bit.
REQ-009 The block SHALL use one clock and an asynchronous, active-high reset (clk, rst).

Function
REQ-010 Selection SHALL be in[sel]; for N_IN=2: sel=0 -> in[0], sel=1 -> in[1].
REQ-011 If sel >= N_IN (non-power-of-two N_IN only), the selected value SHALL be 0.
REQ-012 With REG_OUT=1, out SHALL update on each rising clk edge to the selection computed from in and sel sampled at that edge; latency exactly 1 cycle; out holds between edges.
REQ-013 With REG_OUT=0, out SHALL follow in and sel combinationally with zero cycles of latency; clk and rst have no effect on out.
REQ-014 Changes to in or sel between clock edges SHALL NOT affect out when REG_OUT=1.
REQ-015 Simultaneous changes to in and sel before an edge SHALL both take effect at that edge.
REQ-016 X/Z on an unselected input bit SHALL NOT propagate to out.
REQ-017 No other internal state SHALL exist beyond the single output register.

Reset
REQ-018 With REG_OUT=1, rst=1 SHALL force out to 0 immediately, independent of clk.
REQ-019 While rst=1, out SHALL remain 0 regardless of in, sel, or clock edges.
REQ-020 After rst deasserts, the first rising clk edge SHALL load in[sel] (subject to REQ-011).
REQ-021 Reset asserted mid-operation SHALL override any pending update; no stale value is output after release until the next edge.

Verification
REQ-022 Default params, rst pulse then sel=0, in cycling 00,01,10,11 on successive edges -> out 0,1,0,1, one cycle after each value is applied.
REQ-023 sel=1, in cycling 00,01,10,11 -> out 0,0,1,1 with 1-cycle latency; toggling sel when in==11 -> out stays 1 for the next cycle.
REQ-024 in=11, sel=1, out=1; assert rst between edges -> out=0 immediately; holds 0 across 3 edges; release -> out=1 after first edge.
REQ-025 in and sel changed mid-cycle and changed back before the edge -> out unchanged.
REQ-026 N_IN=3, SEL_W=2, in=111: sel=0,1,2 -> out=1; sel=3 -> out=0.
REQ-027 REG_OUT=0, default N_IN: exhaustive 8 combinations of {in,sel} -> out=in[sel] with no clock applied.

Source files
------------

// File: rtl/mux.sv
// rtl/mux.sv - parameterised 1-of-N_IN bit multiplexer with optional output register
//
// Parameters:
//   N_IN    number of 1-bit candidates (2..64)
//   SEL_W   select width, must equal $clog2(N_IN)
//   REG_OUT 1 = out registered on clk, 0 = out purely combinational
// Ports:
//   clk  in   rising-edge clock (used only when REG_OUT=1)
//   rst  in   asynchronous active-high reset (used only when REG_OUT=1)
//   in   in   [N_IN-1:0] candidate data bits
//   sel  in   [SEL_W-1:0] index of the bit routed to out
//   out  out  selected bit; 0 when sel addresses a non-existent candidate

module mux #(
  parameter int N_IN    = 2,
  parameter int SEL_W   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  generate
    if (N_IN < 2 || N_IN > 64 || SEL_W != $clog2(N_IN)) begin : g_bad_param
      $error("mux: illegal parameters N_IN=%0d SEL_W=%0d", N_IN, SEL_W);
    end
  endgenerate

  logic sel_bit;

  // Decode by explicit compare against each legal index: out-of-range
  // select values (non-power-of-two N_IN) match nothing and yield 0, and
  // only the matched bit reaches sel_bit, so X on other bits stays out.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == i[SEL_W-1:0]) begin
        sel_bit = in[i];
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= 1'b0;
        end else begin
          out_q <= sel_bit;
        end
      end

      assign out = out_q;
    end else begin : g_comb
      assign out = sel_bit;
    end
  endgenerate

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - directed self-checking bench for mux (registered, 3-input, combinational)
//
// Instances:
//   dut_a  defaults (N_IN=2, SEL_W=1, REG_OUT=1)
//   dut_b  N_IN=3, SEL_W=2, REG_OUT=1
//   dut_c  N_IN=2, SEL_W=1, REG_OUT=0

module tb_mux;

  logic       clk;
  logic       rst;
  logic [1:0] in_a;
  logic       sel_a;
  logic       out_a;
  logic [2:0] in_b;
  logic [1:0] sel_b;
  logic       out_b;
  logic [1:0] in_c;
  logic       sel_c;
  logic       out_c;

  int compared;
  int mismatched;

  mux #(.N_IN(2), .SEL_W(1), .REG_OUT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .in  (in_a),
    .sel (sel_a),
    .out (out_a)
  );

  mux #(.N_IN(3), .SEL_W(2), .REG_OUT(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .in  (in_b),
    .sel (sel_b),
    .out (out_b)
  );

  mux #(.N_IN(2), .SEL_W(1), .REG_OUT(0)) dut_c (
    .clk (clk),
    .rst (rst),
    .in  (in_c),
    .sel (sel_c),
    .out (out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0] in_seq [4];
    logic       exp_sel0 [4];
    logic       exp_sel1 [4];
    logic       exp_b [4];
    logic       exp_c [8];

    in_seq   = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_sel0 = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_sel1 = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_b    = '{1'b1, 1'b1, 1'b1, 1'b0};
    // {in[1:0], sel} = 000..111 -> in[sel]
    exp_c    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    compared   = 0;
    mismatched = 0;

    rst   = 1'b1;
    in_a  = 2'b11;
    sel_a = 1'b1;
    in_b  = 3'b111;
    sel_b = 2'd0;
    in_c  = 2'b00;
    sel_c = 1'b0;

    // Reset state with selected inputs at 1
    #1;
    check("reset_a", out_a, 1'b0);
    check("reset_b", out_b, 1'b0);

    // Combinational instance: exhaustive, while rst is held high
    for (int k = 0; k < 8; k++) begin
      in_c  = k[2:1];
      sel_c = k[0];
      #1;
      check($sformatf("comb_%0d", k), out_c, exp_c[k]);
    end

    @(negedge clk);
    rst  = 1'b0;
    in_a = 2'b00;
    sel_a = 1'b0;
    #1;
    check("no_stale_after_release", out_a, 1'b0);

    // sel=0, in cycling: out = in[0] one cycle after each value is applied
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_a = in_seq[k];
      @(negedge clk);
      check($sformatf("sel0_in%0d", k), out_a, exp_sel0[k]);
    end

    // sel=1, in cycling: out = in[1]; out holds until the edge
    sel_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_a = in_seq[k];
      @(negedge clk);
      check($sformatf("sel1_in%0d", k), out_a, exp_sel1[k]);
    end

    // in==11, toggle sel -> stays 1
    @(negedge clk);
    sel_a = 1'b0;
    @(negedge clk);
    check("toggle_sel_in11", out_a, 1'b1);

    // Latency: a change right after a negedge is not visible before the edge
    in_a = 2'b10;
    #1;
    check("hold_between_edges", out_a, 1'b1);
    @(negedge clk);
    check("load_after_edge", out_a, 1'b0);

    // Async reset between edges
    in_a  = 2'b11;
    sel_a = 1'b1;
    @(negedge clk);
    check("pre_reset_one", out_a, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", out_a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("reset_hold_%0d", k), out_a, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("release_no_stale", out_a, 1'b0);
    @(negedge clk);
    check("release_first_edge", out_a, 1'b1);

    // Glitch on in and sel between edges, restored before the edge
    in_a  = 2'b01;
    sel_a = 1'b0;
    @(negedge clk);
    check("glitch_base", out_a, 1'b1);
    #2;
    in_a  = 2'b00;
    sel_a = 1'b1;
    #1;
    check("glitch_mid", out_a, 1'b1);
    #1;
    in_a  = 2'b01;
    sel_a = 1'b0;
    @(negedge clk);
    check("glitch_restored", out_a, 1'b1);

    // Simultaneous in and sel change both taken at the edge
    in_a  = 2'b10;
    sel_a = 1'b1;
    @(negedge clk);
    check("simultaneous_change", out_a, 1'b1);

    // X on the unselected bit must not reach out
    in_a  = 2'bx0;
    sel_a = 1'b0;
    @(negedge clk);
    check("x_unselected_0", out_a, 1'b0);
    in_a  = 2'b1x;
    sel_a = 1'b1;
    @(negedge clk);
    check("x_unselected_1", out_a, 1'b1);

    // N_IN=3: sel 0..2 pick 1, sel 3 out of range -> 0
    in_b = 3'b111;
    for (int k = 0; k < 4; k++) begin
      sel_b = k[1:0];
      @(negedge clk);
      check($sformatf("n3_sel%0d", k), out_b, exp_b[k]);
    end
    in_b  = 3'b011;
    sel_b = 2'd2;
    @(negedge clk);
    check("n3_sel2_zero", out_b, 1'b0);
    in_b  = 3'b100;
    @(negedge clk);
    check("n3_sel2_one", out_b, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
